// File: rtl/inst_decode_queue.sv
// DEPTH-entry instruction queue between fetch and execute; the head entry is split into MIPS fields.
// Optional stall counter output is enabled by defining INST_DECODE_QUEUE_STALL_CNT_EN.
module inst_decode_queue #(
    parameter int INST_MEM_WIDTH = 2,
    parameter int DEPTH          = 4,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                          CLK,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [31:0]                   inst,
    input  logic [INST_MEM_WIDTH-1:0]     pc,
    input  logic [INST_MEM_WIDTH-1:0]     pc1,
    input  logic                          distinct,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [5:0]                    opcode,
    output logic [4:0]                    rs,
    output logic [4:0]                    rt,
    output logic [4:0]                    rd,
    output logic [4:0]                    sa,
    output logic [5:0]                    funct,
    output logic [15:0]                   immediate,
    output logic [25:0]                   inst_index,
    output logic [INST_MEM_WIDTH-1:0]     pc_next,
    output logic [INST_MEM_WIDTH-1:0]     pc1_next,
    output logic                          distinct_next,
`ifdef INST_DECODE_QUEUE_STALL_CNT_EN
    output logic [CNT_WIDTH-1:0]          stall_cycles,
`endif
    output logic [$clog2(DEPTH+1)-1:0]    count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [31:0]               mem_inst_q     [DEPTH];
    logic [INST_MEM_WIDTH-1:0] mem_pc_q       [DEPTH];
    logic [INST_MEM_WIDTH-1:0] mem_pc1_q      [DEPTH];
    logic                      mem_distinct_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic enq;
    logic deq;
    logic [31:0] head_inst;

    // Ready is a pure function of occupancy, so a full queue refuses even when draining.
    assign in_ready  = (count_q != CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign enq       = in_valid && in_ready;
    assign deq       = out_valid && out_ready;
    assign count     = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq) wr_ptr_d = wr_ptr_q + PW'(1);
            if (deq) rd_ptr_d = rd_ptr_q + PW'(1);
            case ({enq, deq})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // A flushed enqueue must not touch storage, so the write is gated by flush too.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge CLK) begin
                if (reset) begin
                    mem_inst_q[gi]     <= '0;
                    mem_pc_q[gi]       <= '0;
                    mem_pc1_q[gi]      <= '0;
                    mem_distinct_q[gi] <= 1'b0;
                end else if (enq && !flush && (wr_ptr_q == PW'(gi))) begin
                    mem_inst_q[gi]     <= inst;
                    mem_pc_q[gi]       <= pc;
                    mem_pc1_q[gi]      <= pc1;
                    mem_distinct_q[gi] <= distinct;
                end
            end
        end
    endgenerate

    // Empty queue presents all-zero fields, which downstream decodes as a nop.
    assign head_inst     = out_valid ? mem_inst_q[rd_ptr_q]     : 32'd0;
    assign pc_next       = out_valid ? mem_pc_q[rd_ptr_q]       : '0;
    assign pc1_next      = out_valid ? mem_pc1_q[rd_ptr_q]      : '0;
    assign distinct_next = out_valid ? mem_distinct_q[rd_ptr_q] : 1'b0;

    assign opcode     = head_inst[31:26];
    assign rs         = head_inst[25:21];
    assign rt         = head_inst[20:16];
    assign rd         = head_inst[15:11];
    assign sa         = head_inst[10:6];
    assign funct      = head_inst[5:0];
    assign immediate  = head_inst[15:0];
    assign inst_index = head_inst[25:0];

`ifdef INST_DECODE_QUEUE_STALL_CNT_EN
    logic [CNT_WIDTH-1:0] stall_q;

    always_ff @(posedge CLK) begin
        if (reset) begin
            stall_q <= '0;
        end else if (out_valid && !out_ready && (stall_q != {CNT_WIDTH{1'b1}})) begin
            stall_q <= stall_q + CNT_WIDTH'(1);
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_inst_decode_queue.sv
// Directed self-checking bench for inst_decode_queue (DEPTH=4, INST_MEM_WIDTH=2).
module tb_inst_decode_queue;

    logic        CLK = 1'b0;
    logic        reset, flush, in_valid, out_ready, distinct;
    logic [31:0] inst;
    logic [1:0]  pc, pc1;
    logic        in_ready, out_valid, distinct_next;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, sa;
    logic [15:0] immediate;
    logic [25:0] inst_index;
    logic [1:0]  pc_next, pc1_next;
    logic [2:0]  count;
`ifdef INST_DECODE_QUEUE_STALL_CNT_EN
    logic [15:0] stall_cycles;
`endif

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    inst_decode_queue #(.INST_MEM_WIDTH(2), .DEPTH(4), .CNT_WIDTH(16)) dut (
        .CLK(CLK), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .inst(inst), .pc(pc), .pc1(pc1), .distinct(distinct),
        .out_valid(out_valid), .out_ready(out_ready),
        .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .sa(sa), .funct(funct),
        .immediate(immediate), .inst_index(inst_index),
        .pc_next(pc_next), .pc1_next(pc1_next), .distinct_next(distinct_next),
`ifdef INST_DECODE_QUEUE_STALL_CNT_EN
        .stall_cycles(stall_cycles),
`endif
        .count(count)
    );

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        flush = 0; in_valid = 0; out_ready = 0; distinct = 0;
        inst = '0; pc = '0; pc1 = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        step(); step();
        reset = 0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (opcode !== 6'd0) begin failures++; $display("FAIL reset_opcode got=%0h exp=0", opcode); end
        checks++; if (inst_index !== 26'd0) begin failures++; $display("FAIL reset_inst_index got=%0h exp=0", inst_index); end
    endtask

    task automatic test_single_pass();
        in_valid = 1; inst = 32'h8C22_0004; pc = 2'd1; pc1 = 2'd2; distinct = 1; out_ready = 1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_no_bypass got=%0b exp=0", out_valid); end
        step();
        in_valid = 0;
        $display("txn enq inst=8c220004 -> head opcode=%0h rs=%0d rt=%0d imm=%0h", opcode, rs, rt, immediate);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_out_valid got=%0b exp=1", out_valid); end
        checks++; if (opcode !== 6'h23) begin failures++; $display("FAIL single_opcode got=%0h exp=23", opcode); end
        checks++; if (rs !== 5'd1) begin failures++; $display("FAIL single_rs got=%0d exp=1", rs); end
        checks++; if (rt !== 5'd2) begin failures++; $display("FAIL single_rt got=%0d exp=2", rt); end
        checks++; if (rd !== 5'd0 || sa !== 5'd0 || funct !== 6'd4) begin failures++; $display("FAIL single_rd_sa_funct got=%0d/%0d/%0d exp=0/0/4", rd, sa, funct); end
        checks++; if (immediate !== 16'h0004) begin failures++; $display("FAIL single_imm got=%0h exp=4", immediate); end
        checks++; if (inst_index !== 26'h0220004) begin failures++; $display("FAIL single_inst_index got=%0h exp=220004", inst_index); end
        checks++; if (pc_next !== 2'd1 || pc1_next !== 2'd2) begin failures++; $display("FAIL single_pc got=%0d/%0d exp=1/2", pc_next, pc1_next); end
        checks++; if (distinct_next !== 1'b1) begin failures++; $display("FAIL single_distinct got=%0b exp=1", distinct_next); end
        step();
        out_ready = 0;
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL single_drained got=%0d exp=0", count); end
        checks++; if (opcode !== 6'd0 || pc_next !== 2'd0) begin failures++; $display("FAIL single_empty_zero got=%0h/%0d exp=0/0", opcode, pc_next); end
    endtask

    task automatic test_fill_order();
        out_ready = 0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1; inst = 32'h11 * (k + 1); pc = 2'(k); pc1 = 2'(k + 1); distinct = k[0];
            step();
        end
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL fill_count got=%0d exp=4", count); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL fill_in_ready got=%0b exp=0", in_ready); end
        in_valid = 1; inst = 32'h55;
        step();
        in_valid = 0;
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL fill_fifth_count got=%0d exp=4", count); end
        checks++; if (immediate !== 16'h11) begin failures++; $display("FAIL fill_head_stable got=%0h exp=11", immediate); end
        out_ready = 1;
        for (int k = 0; k < 4; k++) begin
            $display("txn deq imm=%0h pc=%0d pc1=%0d", immediate, pc_next, pc1_next);
            checks++; if (immediate !== 16'(16'h11 * (k + 1))) begin failures++; $display("FAIL fill_order%0d got=%0h exp=%0h", k, immediate, 16'h11 * (k + 1)); end
            checks++; if (pc_next !== 2'(k) || pc1_next !== 2'(k + 1)) begin failures++; $display("FAIL fill_pc%0d got=%0d/%0d exp=%0d/%0d", k, pc_next, pc1_next, k[1:0], 2'(k + 1)); end
            step();
        end
        out_ready = 0;
        checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL fill_empty got=%0d/%0b exp=0/0", count, out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1; inst = 32'h100 + k;
            step();
        end
        out_ready = 1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1; inst = 32'h102 + i;
            checks++; if (count !== 3'd2) begin failures++; $display("FAIL b2b_count%0d got=%0d exp=2", i, count); end
            checks++; if (immediate !== 16'(16'h100 + i)) begin failures++; $display("FAIL b2b_head%0d got=%0h exp=%0h", i, immediate, 16'h100 + i); end
            $display("txn enq=%0h deq=%0h", inst, immediate);
            step();
        end
        in_valid = 0;
        for (int i = 10; i < 12; i++) begin
            checks++; if (immediate !== 16'(16'h100 + i)) begin failures++; $display("FAIL b2b_tail%0d got=%0h exp=%0h", i, immediate, 16'h100 + i); end
            step();
        end
        out_ready = 0;
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL b2b_empty got=%0d exp=0", count); end
    endtask

    task automatic test_flush();
        out_ready = 0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1; inst = 32'h201 + k; pc = 2'd3; pc1 = 2'd3; distinct = 1;
            step();
        end
        checks++; if (count !== 3'd3) begin failures++; $display("FAIL flush_pre_count got=%0d exp=3", count); end
        flush = 1; in_valid = 1; inst = 32'h2FF;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_in_ready got=%0b exp=1", in_ready); end
        step();
        flush = 0; in_valid = 0;
        checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL flush_count got=%0d/%0b exp=0/0", count, out_valid); end
        checks++; if (immediate !== 16'd0 || pc_next !== 2'd0 || distinct_next !== 1'b0) begin failures++; $display("FAIL flush_zero got=%0h/%0d/%0b exp=0/0/0", immediate, pc_next, distinct_next); end
        step();
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL flush_no_ghost got=%0d exp=0", count); end
        in_valid = 1; inst = 32'h301; distinct = 0;
        step();
        in_valid = 0;
        checks++; if (immediate !== 16'h301 || count !== 3'd1) begin failures++; $display("FAIL flush_after got=%0h/%0d exp=301/1", immediate, count); end
        out_ready = 1;
        step();
        out_ready = 0;
    endtask

    task automatic test_reset_mid();
        in_valid = 1; inst = 32'h401;
        step();
        inst = 32'h402;
        step();
        reset = 1; flush = 1; inst = 32'h4FF;
        step();
        reset = 0; flush = 0; in_valid = 0;
        checks++; if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_state got=%0d/%0b/%0b exp=0/0/1", count, out_valid, in_ready); end
        in_valid = 1; inst = 32'h0000_0503; pc = 2'd2;
        step();
        in_valid = 0;
        checks++; if (immediate !== 16'h503 || pc_next !== 2'd2) begin failures++; $display("FAIL rstmid_after got=%0h/%0d exp=503/2", immediate, pc_next); end
        out_ready = 1;
        step();
        out_ready = 0;
    endtask

`ifdef INST_DECODE_QUEUE_STALL_CNT_EN
    task automatic test_stall_cnt();
        reset = 1;
        step();
        reset = 0;
        checks++; if (stall_cycles !== 16'd0) begin failures++; $display("FAIL stall_reset got=%0d exp=0", stall_cycles); end
        in_valid = 1; inst = 32'h600; out_ready = 0;
        step();
        in_valid = 0;
        repeat (5) step();
        checks++; if (stall_cycles !== 16'd5) begin failures++; $display("FAIL stall_five got=%0d exp=5", stall_cycles); end
        flush = 1; out_ready = 1;
        step();
        flush = 0; out_ready = 0;
        step();
        checks++; if (stall_cycles !== 16'd5) begin failures++; $display("FAIL stall_flush got=%0d exp=5", stall_cycles); end
        reset = 1;
        step();
        reset = 0;
        checks++; if (stall_cycles !== 16'd0) begin failures++; $display("FAIL stall_clear got=%0d exp=0", stall_cycles); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_pass();
        test_fill_order();
        test_back_to_back();
        test_flush();
        test_reset_mid();
`ifdef INST_DECODE_QUEUE_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inst_decode_queue.md
Name: inst_decode_queue

Overview:
- Parametrised successor to the single-register decode stage: a DEPTH-entry instruction queue between fetch and execute with valid/ready handshakes on both sides, plus a flush input.
- Each entry holds {inst, pc, pc1, distinct}.
- The head entry is split into MIPS-style fields (opcode, rs, rt, rd, sa, funct, immediate, inst_index) for the operator/control logic downstream.
- Absorbs fetch/execute rate mismatch. Branch redirect drops every queued instruction in one cycle.

Parameters:
INST_MEM_WIDTH, 2, width of pc/pc1 (instruction memory address bits)
DEPTH, 4, number of queue entries; power of two, >= 2
CNT_WIDTH, 16, width of stall counter (optional feature only)

Ports:
CLK  in  1  clock, all state on posedge
reset  in  1  synchronous, active-high reset
flush  in  1  discard all queued entries (branch/jump redirect)
in_valid  in  1  fetch presents an instruction
in_ready  out  1  queue can accept; = (count != DEPTH)
inst  in  32  fetched instruction word
pc  in  INST_MEM_WIDTH  address of inst
pc1  in  INST_MEM_WIDTH  pc + 1 from fetch
distinct  in  1  fetch-side tag bit, carried with the entry
out_valid  out  1  head entry present; = (count != 0)
out_ready  in  1  execute consumes head this cycle
opcode  out  6  head inst[31:26]
rs  out  5  head inst[25:21]
rt  out  5  head inst[20:16]
rd  out  5  head inst[15:11]
sa  out  5  head inst[10:6]
funct  out  6  head inst[5:0]
immediate  out  16  head inst[15:0]
inst_index  out  26  head inst[25:0]
pc_next  out  INST_MEM_WIDTH  head pc
pc1_next  out  INST_MEM_WIDTH  head pc1
distinct_next  out  1  head distinct
count  out  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Storage: DEPTH-entry circular buffer with wr_ptr and rd_ptr, each log2(DEPTH) bits, wrapping modulo DEPTH. Separate count register, 0..DEPTH.
- Occupancy states: EMPTY (count=0), PARTIAL, FULL (count=DEPTH).
- Enqueue = in_valid && in_ready. Writes entry at wr_ptr; wr_ptr++.
- Dequeue = out_valid && out_ready. rd_ptr++.
- Simultaneous enqueue and dequeue in PARTIAL: count unchanged, both pointers advance.
- When FULL, in_ready=0 even if dequeue occurs that cycle. There is no combinational ready path from out_ready.
- Enqueue while EMPTY: no same-cycle bypass. out_valid rises the next cycle. Latency is 1 cycle from enqueue to visibility at the head.
- All outputs derive from registers only; none depend combinationally on in_* or out_ready.
- When EMPTY, all field outputs, pc_next, pc1_next and distinct_next are driven 0. This matches the nop encoding, so downstream control decodes a nop.
- Head outputs are stable while out_valid=1 and out_ready=0.
- in_valid while in_ready=0: input ignored. Fetch must hold the instruction.
- flush=1: next cycle count=0 and wr_ptr=rd_ptr=0.
  - Any same-cycle enqueue is discarded.
  - Any same-cycle dequeue is irrelevant.
  - Flush has priority over all traffic. in_ready is still computed from current count during the flush cycle.
- reset=1: same effect as flush, and also clears stored entries to 0.
  - Reset mid-operation discards everything.
  - Reset has priority over flush.
- Reset values: out_valid=0, in_ready=1, count=0, all data outputs 0.

Optional Feature:
- Macro: INST_DECODE_QUEUE_STALL_CNT_EN.
- Defined:
  - Adds output port stall_cycles [CNT_WIDTH-1:0].
  - Increments each cycle with out_valid && !out_ready.
  - Saturates at all-ones.
  - Cleared by reset only, not by flush.
- Undefined: port and counter absent. Queue behaviour is identical in both builds.

Test Plan:
- Reset then idle: reset high 2 cycles -> out_valid=0, in_ready=1, count=0, opcode=0, inst_index=0.
- Single pass: enqueue inst=0x8C220004, pc=1, pc1=2, distinct=1, out_ready=1.
  - Next cycle: out_valid=1, opcode=0x23, rs=1, rt=2, immediate=0x0004, pc_next=1, pc1_next=2, distinct_next=1.
  - Following cycle: count=0.
- Fill and order (DEPTH=4):
  - out_ready=0, enqueue inst 0x11,0x22,0x33,0x44 -> count=4, in_ready=0.
  - A fifth in_valid is ignored.
  - Then out_ready=1 -> heads appear 0x11,0x22,0x33,0x44 in order, and pointers wrap.
- Simultaneous traffic: at count=2, enqueue and dequeue each cycle for 10 cycles -> count stays 2, output order matches input order, no drops.
- Flush: count=3 with flush=1 and in_valid=1 in the same cycle -> next cycle count=0, out_valid=0, outputs 0, flushed enqueue never appears.
- Stall counter (macro defined): head valid, out_ready=0 for 5 cycles -> stall_cycles=5. A flush leaves it at 5. Reset clears it to 0.
